pll_md_ctrl: RTL and testbench

//  Initiator for the PLLA dynamic-config (MD) port: turns single-byte read/write/commit requests

---
 rtl/pll_md_ctrl_if.sv | 21 ++
 rtl/pll_md_ctrl.sv | 254 +++++++++++++++++++++++++
 tb/tb_pll_md_ctrl.sv | 263 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/pll_md_ctrl_if.sv
// Request/response bus between the system register bus and the PLL MD-port controller.
interface pll_md_ctrl_if;
  logic       req_valid;
  logic       req_ready;
  logic [1:0] req_op;
  logic [7:0] req_addr;
  logic [7:0] req_wdata;
  logic       rsp_valid;
  logic [7:0] rsp_rdata;
  logic       rsp_err;

  modport master (
    output req_valid, req_op, req_addr, req_wdata,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_op, req_addr, req_wdata,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );
endinterface

// File: rtl/pll_md_ctrl.sv
// PLLA dynamic-config (MD) port initiator: single-byte read/write/commit requests,
// MD phase sequencing on MDCLK falling boundaries, PLL reset and relock handling.
// Optional build macro PLL_MD_VERIFY_EN adds a readback check after every write.
module pll_md_ctrl #(
  parameter int unsigned MDCLK_HALF   = 2,
  parameter int unsigned RST_CYCLES   = 8,
  parameter int unsigned LOCK_TIMEOUT = 1024
) (
  input  logic         clkin,
  input  logic         reset,
  pll_md_ctrl_if.slave bus,
  output logic         busy,
  output logic         pll_mdclk,
  output logic [1:0]   pll_mdopc,
  output logic         pll_mdainc,
  output logic [7:0]   pll_mdwdi,
  input  logic [7:0]   pll_mdrdo,
  output logic         pll_reset,
  input  logic         pll_lock
);

  localparam int unsigned DIV_W   = (MDCLK_HALF > 1) ? $clog2(MDCLK_HALF) : 1;
  localparam int unsigned CNT_MAX = (LOCK_TIMEOUT > RST_CYCLES) ? LOCK_TIMEOUT : RST_CYCLES;
  localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

  localparam logic [1:0] OPC_NOP  = 2'b00;
  localparam logic [1:0] OPC_ADDR = 2'b11;
  localparam logic [1:0] OPC_WR   = 2'b01;
  localparam logic [1:0] OPC_RD   = 2'b10;

  localparam logic [1:0] OP_RD    = 2'b01;
  localparam logic [1:0] OP_WRC   = 2'b10;
  localparam logic [1:0] OP_CMT   = 2'b11;

  typedef enum logic [3:0] {
    S_BRST, S_BLOCK, S_IDLE, S_WAIT, S_ADDR, S_DATA, S_GAP,
    S_VADDR, S_VREAD, S_VGAP, S_RST, S_LOCK, S_RESP
  } state_t;

  state_t           state_q, state_n;
  logic [CNT_W-1:0] cnt_q, cnt_n;
  logic [1:0]       op_q, op_n;
  logic [7:0]       addr_q, addr_n, wdata_q, wdata_n, rd_q, rd_n;
  logic             verr_q, verr_n;
  logic [1:0]       mdopc_q, mdopc_n;
  logic [7:0]       mdwdi_q, mdwdi_n;
  logic             pll_reset_q, pll_reset_n;
  logic             req_ready_q, req_ready_n, busy_q, busy_n;
  logic             rsp_valid_q, rsp_valid_n, rsp_err_q, rsp_err_n;
  logic [7:0]       rsp_rdata_q, rsp_rdata_n;

  logic [DIV_W-1:0] div_q;
  logic             mdclk_q;
  logic             boundary_c;

  // Boundary: the clkin edge on which MDCLK falls; MD outputs only change there.
  assign boundary_c = mdclk_q && (div_q == DIV_W'(MDCLK_HALF - 1));

  // Free-running MDCLK divider.
  always_ff @(posedge clkin) begin
    if (reset) begin
      div_q   <= '0;
      mdclk_q <= 1'b0;
    end else if (div_q == DIV_W'(MDCLK_HALF - 1)) begin
      div_q   <= '0;
      mdclk_q <= ~mdclk_q;
    end else begin
      div_q   <= div_q + DIV_W'(1);
    end
  end

  // State and registered-output update.
  always_ff @(posedge clkin) begin
    if (reset) begin
      state_q     <= S_BRST;
      cnt_q       <= '0;
      op_q        <= '0;
      addr_q      <= '0;
      wdata_q     <= '0;
      rd_q        <= '0;
      verr_q      <= 1'b0;
      mdopc_q     <= OPC_NOP;
      mdwdi_q     <= '0;
      pll_reset_q <= 1'b1;
      req_ready_q <= 1'b0;
      busy_q      <= 1'b1;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_n;
      cnt_q       <= cnt_n;
      op_q        <= op_n;
      addr_q      <= addr_n;
      wdata_q     <= wdata_n;
      rd_q        <= rd_n;
      verr_q      <= verr_n;
      mdopc_q     <= mdopc_n;
      mdwdi_q     <= mdwdi_n;
      pll_reset_q <= pll_reset_n;
      req_ready_q <= req_ready_n;
      busy_q      <= busy_n;
      rsp_valid_q <= rsp_valid_n;
      rsp_rdata_q <= rsp_rdata_n;
      rsp_err_q   <= rsp_err_n;
    end
  end

  // Next-state and next-output decode.
  always_comb begin
    state_n     = state_q;
    cnt_n       = cnt_q;
    op_n        = op_q;
    addr_n      = addr_q;
    wdata_n     = wdata_q;
    rd_n        = rd_q;
    verr_n      = verr_q;
    mdopc_n     = mdopc_q;
    mdwdi_n     = mdwdi_q;
    pll_reset_n = 1'b0;
    rsp_valid_n = 1'b0;
    rsp_rdata_n = '0;
    rsp_err_n   = 1'b0;

    case (state_q)
      S_BRST, S_RST: begin
        pll_reset_n = 1'b1;
        if (cnt_q == CNT_W'(RST_CYCLES - 1)) begin
          pll_reset_n = 1'b0;
          cnt_n       = '0;
          state_n     = (state_q == S_BRST) ? S_BLOCK : S_LOCK;
        end else begin
          cnt_n = cnt_q + CNT_W'(1);
        end
      end
      // Boot relock: a timeout still opens the bus, a later commit can retry.
      S_BLOCK: begin
        if (pll_lock || (cnt_q == CNT_W'(LOCK_TIMEOUT - 1))) begin
          state_n = S_IDLE;
          cnt_n   = '0;
        end else begin
          cnt_n = cnt_q + CNT_W'(1);
        end
      end
      S_IDLE: begin
        if (bus.req_valid) begin
          op_n    = bus.req_op;
          addr_n  = bus.req_addr;
          wdata_n = bus.req_wdata;
          rd_n    = '0;
          verr_n  = 1'b0;
          if (bus.req_op == OP_CMT) begin
            state_n     = S_RST;
            pll_reset_n = 1'b1;
            cnt_n       = '0;
          end else begin
            state_n = S_WAIT;
          end
        end
      end
      S_WAIT: if (boundary_c) begin
        state_n = S_ADDR;
        mdopc_n = OPC_ADDR;
        mdwdi_n = addr_q;
      end
      S_ADDR: if (boundary_c) begin
        state_n = S_DATA;
        mdopc_n = (op_q == OP_RD) ? OPC_RD : OPC_WR;
        mdwdi_n = (op_q == OP_RD) ? 8'h00 : wdata_q;
      end
      S_DATA, S_VREAD: if (boundary_c) begin
        state_n = (state_q == S_DATA) ? S_GAP : S_VGAP;
        mdopc_n = OPC_NOP;
        mdwdi_n = '0;
      end
      S_GAP: if (boundary_c) begin
        if (op_q == OP_RD) begin
          rd_n        = pll_mdrdo;
          state_n     = S_RESP;
          rsp_valid_n = 1'b1;
          rsp_rdata_n = pll_mdrdo;
        end
`ifdef PLL_MD_VERIFY_EN
        else begin
          state_n = S_VADDR;
          mdopc_n = OPC_ADDR;
          mdwdi_n = addr_q;
        end
`else
        else if (op_q == OP_WRC) begin
          state_n     = S_RST;
          pll_reset_n = 1'b1;
          cnt_n       = '0;
        end else begin
          state_n     = S_RESP;
          rsp_valid_n = 1'b1;
        end
`endif
      end
      S_VADDR: if (boundary_c) begin
        state_n = S_VREAD;
        mdopc_n = OPC_RD;
        mdwdi_n = '0;
      end
      // Readback compare; a commit still runs after a mismatch.
      S_VGAP: if (boundary_c) begin
        rd_n   = pll_mdrdo;
        verr_n = (pll_mdrdo != wdata_q);
        if (op_q == OP_WRC) begin
          state_n     = S_RST;
          pll_reset_n = 1'b1;
          cnt_n       = '0;
        end else begin
          state_n     = S_RESP;
          rsp_valid_n = 1'b1;
          rsp_rdata_n = rd_n;
          rsp_err_n   = verr_n;
        end
      end
      S_LOCK: begin
        if (pll_lock) begin
          state_n     = S_RESP;
          rsp_valid_n = 1'b1;
          rsp_rdata_n = rd_q;
          rsp_err_n   = verr_q;
        end else if (cnt_q == CNT_W'(LOCK_TIMEOUT - 1)) begin
          state_n     = S_RESP;
          rsp_valid_n = 1'b1;
          rsp_rdata_n = rd_q;
          rsp_err_n   = 1'b1;
        end else begin
          cnt_n = cnt_q + CNT_W'(1);
        end
      end
      S_RESP:  state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase

    req_ready_n = (state_n == S_IDLE);
    busy_n      = ~req_ready_n;
  end

  assign bus.req_ready = req_ready_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_rdata = rsp_rdata_q;
  assign bus.rsp_err   = rsp_err_q;
  assign busy          = busy_q;
  assign pll_mdclk     = mdclk_q;
  assign pll_mdopc     = mdopc_q;
  assign pll_mdwdi     = mdwdi_q;
  assign pll_mdainc    = 1'b0;
  assign pll_reset     = pll_reset_q;

endmodule

// File: tb/tb_pll_md_ctrl.sv
// Directed bench for pll_md_ctrl with a small PLL MD-port model (256-byte register file).
module tb_pll_md_ctrl;

  logic       clkin = 1'b0;
  logic       reset = 1'b1;
  logic       busy, pll_mdclk, pll_mdainc, pll_reset;
  logic       pll_lock = 1'b0;
  logic [1:0] pll_mdopc;
  logic [7:0] pll_mdwdi;
  logic [7:0] pll_mdrdo = 8'h00;

  always #5 clkin = ~clkin;

  pll_md_ctrl_if bus ();

  pll_md_ctrl #(.MDCLK_HALF(2), .RST_CYCLES(8), .LOCK_TIMEOUT(64)) dut (
    .clkin      (clkin),
    .reset      (reset),
    .bus        (bus),
    .busy       (busy),
    .pll_mdclk  (pll_mdclk),
    .pll_mdopc  (pll_mdopc),
    .pll_mdainc (pll_mdainc),
    .pll_mdwdi  (pll_mdwdi),
    .pll_mdrdo  (pll_mdrdo),
    .pll_reset  (pll_reset),
    .pll_lock   (pll_lock)
  );

  // PLL model: register file written/read on MDCLK rise, lock 10 cycles after reset falls.
  logic [7:0] regs [256];
  logic [7:0] maddr   = 8'h00;
  logic       corrupt = 1'b0;
  logic       lock_en = 1'b1;
  int         lcnt    = 0;

  initial for (int i = 0; i < 256; i++) regs[i] = 8'h00;

  always @(posedge pll_mdclk) begin
    case (pll_mdopc)
      2'b11: maddr <= pll_mdwdi;
      2'b01: regs[maddr] <= corrupt ? pll_mdwdi + 8'd1 : pll_mdwdi;
      2'b10: pll_mdrdo <= regs[maddr];
      default: ;
    endcase
  end

  always @(posedge clkin) begin
    if (pll_reset) begin
      pll_lock <= 1'b0;
      lcnt     <= 0;
    end else if (lock_en) begin
      if (lcnt == 9) pll_lock <= 1'b1;
      else           lcnt     <= lcnt + 1;
    end
  end

  // MD bus monitor: phase list {opc, wdi, length}, boundary alignment, response timing.
  int          cyc = 0, pstart = 0, gap_cyc = 0, rsp_cyc = 0, align_bad = 0, rsp_cnt = 0;
  logic [1:0]  popc = 2'b00;
  logic [7:0]  pwdi = 8'h00;
  logic        pclk = 1'b0;
  logic [25:0] ph [$];

  always @(negedge clkin) begin
    cyc <= cyc + 1;
    if (bus.rsp_valid) begin
      rsp_cnt <= rsp_cnt + 1;
      rsp_cyc <= cyc;
    end
    if ({pll_mdopc, pll_mdwdi} != {popc, pwdi}) begin
      if (!(pclk && !pll_mdclk) && !reset) align_bad <= align_bad + 1;
      if (popc != 2'b00) ph.push_back({popc, pwdi, 16'(cyc - pstart)});
      if (pll_mdopc == 2'b00) gap_cyc <= cyc;
      pstart <= cyc;
    end
    popc <= pll_mdopc;
    pwdi <= pll_mdwdi;
    pclk <= pll_mdclk;
  end

  int n_chk = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [25:0] phe(input int i);
    return (i < ph.size()) ? ph[i] : 26'h0;
  endfunction

  task automatic step();
    @(negedge clkin);
    #1;
  endtask

  task automatic send(input logic [1:0] op, input logic [7:0] a, input logic [7:0] d);
    ph.delete();
    bus.req_valid = 1'b1;
    bus.req_op    = op;
    bus.req_addr  = a;
    bus.req_wdata = d;
    step();
    bus.req_valid = 1'b0;
  endtask

  task automatic wait_rsp(input string tag, output logic [7:0] rd, output logic er);
    int n = 0;
    while (!bus.rsp_valid && n < 2000) begin
      step();
      n++;
    end
    check({tag, "_rsp_seen"}, 32'(bus.rsp_valid), 1);
    rd = bus.rsp_rdata;
    er = bus.rsp_err;
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_mdclk"}, 32'(pll_mdclk), 0);
    check({tag, "_mdopc"}, 32'(pll_mdopc), 0);
    check({tag, "_mdwdi"}, 32'(pll_mdwdi), 0);
    check({tag, "_mdainc"}, 32'(pll_mdainc), 0);
    check({tag, "_pll_reset"}, 32'(pll_reset), 1);
    check({tag, "_req_ready"}, 32'(bus.req_ready), 0);
    check({tag, "_rsp_valid"}, 32'(bus.rsp_valid), 0);
    check({tag, "_rsp_rdata"}, 32'(bus.rsp_rdata), 0);
    check({tag, "_rsp_err"}, 32'(bus.rsp_err), 0);
    check({tag, "_busy"}, 32'(busy), 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] rd;
    logic       er;
    int         n;

    bus.req_valid = 1'b0;
    bus.req_op    = 2'b00;
    bus.req_addr  = 8'h00;
    bus.req_wdata = 8'h00;
    reset = 1'b1;
    repeat (3) step();
    check_reset_vals("por");

    // Boot: 8 cycles of pll_reset, lock 10 cycles later, ready one cycle after lock.
    reset = 1'b0;
    n = 0;
    do begin step(); n++; end while (pll_reset && n < 100);
    check("boot_rst_len", 32'(n), 8);
    n = 0;
    do begin step(); n++; end while (!bus.req_ready && n < 200);
    check("boot_ready_delay", 32'(n), 11);
    check("boot_busy", 32'(busy), 0);
    check("boot_no_rsp", 32'(rsp_cnt), 0);

    // Write 0x12 <- 0x5A.
    send(2'b00, 8'h12, 8'h5A);
    wait_rsp("wr", rd, er);
    check("wr_err", 32'(er), 0);
    check("wr_gap", 32'(rsp_cyc - gap_cyc), 4);
    check("wr_ph0", 32'(phe(0)), {2'b11, 8'h12, 16'd4});
    check("wr_ph1", 32'(phe(1)), {2'b01, 8'h5A, 16'd4});
`ifdef PLL_MD_VERIFY_EN
    check("wr_rdata", 32'(rd), 32'h5A);
    check("wr_nph", 32'(ph.size()), 4);
    check("wr_ph2", 32'(phe(2)), {2'b11, 8'h12, 16'd4});
    check("wr_ph3", 32'(phe(3)), {2'b10, 8'h00, 16'd4});
`else
    check("wr_rdata", 32'(rd), 0);
    check("wr_nph", 32'(ph.size()), 2);
`endif
    check("wr_model", 32'(regs[8'h12]), 32'h5A);
    step();
    check("wr_ready_after", 32'(bus.req_ready), 1);
    check("wr_rsp_one_cycle", 32'(bus.rsp_valid), 0);

    // Read 0x12.
    send(2'b01, 8'h12, 8'h00);
    wait_rsp("rd", rd, er);
    check("rd_rdata", 32'(rd), 32'h5A);
    check("rd_err", 32'(er), 0);
    check("rd_nph", 32'(ph.size()), 2);
    check("rd_ph0", 32'(phe(0)), {2'b11, 8'h12, 16'd4});
    check("rd_ph1", 32'(phe(1)), {2'b10, 8'h00, 16'd4});
    check("rd_gap", 32'(rsp_cyc - gap_cyc), 4);
    step();

    // Commit only, lock never returns: 8 cycles reset, timeout 64 cycles after fall.
    lock_en = 1'b0;
    send(2'b11, 8'h00, 8'h00);
    n = 0;
    while (pll_reset && n < 100) begin step(); n++; end
    check("cmt_rst_len", 32'(n), 8);
    n = 0;
    while (!bus.rsp_valid && n < 200) begin step(); n++; end
    check("cmt_timeout_delay", 32'(n), 64);
    check("cmt_err", 32'(bus.rsp_err), 1);
    check("cmt_rdata", 32'(bus.rsp_rdata), 0);
    check("cmt_nph", 32'(ph.size()), 0);
    step();
    check("cmt_ready_after", 32'(bus.req_ready), 1);
    check("cmt_pll_reset_low", 32'(pll_reset), 0);
    lock_en = 1'b1;

    // Model stores 0x5B for a 0x5A write.
    corrupt = 1'b1;
    send(2'b00, 8'h34, 8'h5A);
    wait_rsp("vfy", rd, er);
`ifdef PLL_MD_VERIFY_EN
    check("vfy_rdata", 32'(rd), 32'h5B);
    check("vfy_err", 32'(er), 1);
`else
    check("vfy_rdata", 32'(rd), 0);
    check("vfy_err", 32'(er), 0);
`endif
    check("vfy_model", 32'(regs[8'h34]), 32'h5B);
    corrupt = 1'b0;
    step();

    // Write + commit with lock returning.
    send(2'b10, 8'h20, 8'hA5);
    wait_rsp("wrc", rd, er);
    check("wrc_err", 32'(er), 0);
`ifdef PLL_MD_VERIFY_EN
    check("wrc_rdata", 32'(rd), 32'hA5);
`else
    check("wrc_rdata", 32'(rd), 0);
`endif
    check("wrc_model", 32'(regs[8'h20]), 32'hA5);
    check("md_alignment", 32'(align_bad), 0);
    check("rsp_count", 32'(rsp_cnt), 5);
    step();

    // Reset asserted in the DATA phase of a write.
    send(2'b00, 8'h40, 8'h77);
    n = 0;
    while (pll_mdopc != 2'b01 && n < 100) begin step(); n++; end
    check("rst_reached_data", 32'(pll_mdopc), 1);
    reset = 1'b1;
    step();
    check_reset_vals("midrst");
    step();
    reset = 1'b0;
    n = 0;
    while (!bus.req_ready && n < 300) begin step(); n++; end
    check("midrst_reboot_ready", 32'(bus.req_ready), 1);
    check("midrst_no_rsp", 32'(rsp_cnt), 5);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
